// File: rtl/chacha_xor_stream.sv
// chacha_xor_stream: ChaCha20 keystream buffer and byte-stream XOR front end.
// Requests core blocks, buffers one block, XORs it onto a valid/ready stream.
module chacha_xor_stream #(
  parameter int BLOCK_BYTES = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cfg_load_i,
  input  logic [255:0] cfg_key_i,
  input  logic [95:0]  cfg_nonce_i,
  input  logic [31:0]  cfg_counter_i,
  output logic [255:0] key_o,
  output logic [95:0]  nonce_o,
  output logic [31:0]  counter_o,
  output logic         ks_start_o,
  input  logic         ks_ready_i,
  input  logic         ks_valid_i,
  input  logic [7:0]   ks_byte_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [7:0]   s_data_i,
  input  logic         s_last_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [7:0]   m_data_o,
  output logic         m_last_o,
  output logic         busy_o,
  output logic         err_o
);

  localparam int AW = $clog2(BLOCK_BYTES);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] LAST_IDX =
    CW'(BLOCK_BYTES - 1);
  localparam logic [31:0] CTR_MAX =
    32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    STREAM,
    ERR
  } state_t;

  state_t state;
  state_t state_n;

  logic [7:0]    ks_buf [BLOCK_BYTES];
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] rd_ptr;

  logic cfg_take;
  logic fill_clr;
  logic fill_we;
  logic rd_clr;
  logic rd_inc;
  logic ctr_inc;
  logic err_set;

  assign busy_o = (state != IDLE) &&
                  (state != ERR);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, stream muxing and datapath strobes
  always_comb begin
    state_n    = state;
    ks_start_o = 1'b0;
    s_ready_o  = 1'b0;
    m_valid_o  = 1'b0;
    m_data_o   = 8'h00;
    m_last_o   = 1'b0;
    cfg_take   = 1'b0;
    fill_clr   = 1'b0;
    fill_we    = 1'b0;
    rd_clr     = 1'b0;
    rd_inc     = 1'b0;
    ctr_inc    = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE, ERR: begin
        if (cfg_load_i) begin
          cfg_take = 1'b1;
          state_n  = REQ;
        end
      end
      REQ: begin
        if (ks_ready_i) begin
          ks_start_o = 1'b1;
          fill_clr   = 1'b1;
          state_n    = FILL;
        end
      end
      FILL: begin
        if (ks_valid_i) begin
          fill_we = 1'b1;
          if (fill_cnt == LAST_IDX) begin
            rd_clr  = 1'b1;
            state_n = STREAM;
          end
        end
      end
      STREAM: begin
        m_valid_o = s_valid_i;
        s_ready_o = m_ready_i;
        m_data_o  = s_data_i ^
                    ks_buf[rd_ptr[AW-1:0]];
        m_last_o  = s_last_i;
        if (s_valid_i && m_ready_i) begin
          // last byte wins over block end:
          // the rest of the block is dropped
          if (s_last_i) begin
            state_n = IDLE;
          end else if (rd_ptr == LAST_IDX) begin
            if (counter_o != CTR_MAX) begin
              ctr_inc = 1'b1;
              state_n = REQ;
            end else begin
              err_set = 1'b1;
              state_n = ERR;
            end
          end else begin
            rd_inc = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Key, nonce and block counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_o     <= '0;
      nonce_o   <= '0;
      counter_o <= '0;
    end else if (cfg_take) begin
      key_o     <= cfg_key_i;
      nonce_o   <= cfg_nonce_i;
      counter_o <= cfg_counter_i;
    end else if (ctr_inc) begin
      counter_o <= counter_o + 32'd1;
    end
  end

  // Sticky counter-exhausted flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (cfg_take) begin
      err_o <= 1'b0;
    end else if (err_set) begin
      err_o <= 1'b1;
    end
  end

  // Fill count and read pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_cnt <= '0;
      rd_ptr   <= '0;
    end else begin
      if (fill_clr) begin
        fill_cnt <= '0;
      end else if (fill_we) begin
        fill_cnt <= fill_cnt + CW'(1);
      end
      if (rd_clr) begin
        rd_ptr <= '0;
      end else if (rd_inc) begin
        rd_ptr <= rd_ptr + CW'(1);
      end
    end
  end

  // Keystream buffer; contents need no reset,
  // a block is always refilled before it is read
  always_ff @(posedge clk_i) begin
    if (fill_we && !rst_i) begin
      ks_buf[fill_cnt[AW-1:0]] <= ks_byte_i;
    end
  end

endmodule

// File: tb/tb_chacha_xor_stream.sv
// tb_chacha_xor_stream: scoreboard bench with a delayed keystream stub.
// Expected bytes come from a per-message byte-index keystream model.
module tb_chacha_xor_stream;

  localparam int BB = 64;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         cfg_load_i;
  logic [255:0] cfg_key_i;
  logic [95:0]  cfg_nonce_i;
  logic [31:0]  cfg_counter_i;
  logic [255:0] key_o;
  logic [95:0]  nonce_o;
  logic [31:0]  counter_o;
  logic         ks_start_o;
  logic         ks_ready_i;
  logic         ks_valid_i;
  logic [7:0]   ks_byte_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic [7:0]   s_data_i;
  logic         s_last_i;
  logic         m_valid_o;
  logic         m_ready_i;
  logic [7:0]   m_data_o;
  logic         m_last_o;
  logic         busy_o;
  logic         err_o;

  int checks = 0;
  int failures = 0;

  logic [8:0]  exp_q [$];
  logic [31:0] starts [$];
  logic [31:0] msg_c0;
  int          msg_idx;
  logic [8:0]  mon_e;

  bit rdy_rand = 0;
  bit val_rand = 0;
  bit gap_en = 0;

  always #5 clk = ~clk;

  chacha_xor_stream dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .cfg_load_i(cfg_load_i),
    .cfg_key_i(cfg_key_i),
    .cfg_nonce_i(cfg_nonce_i),
    .cfg_counter_i(cfg_counter_i),
    .key_o(key_o),
    .nonce_o(nonce_o),
    .counter_o(counter_o),
    .ks_start_o(ks_start_o),
    .ks_ready_i(ks_ready_i),
    .ks_valid_i(ks_valid_i),
    .ks_byte_i(ks_byte_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .s_data_i(s_data_i),
    .s_last_i(s_last_i),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_data_o(m_data_o),
    .m_last_o(m_last_o),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // keystream byte i of a message: block i/BB
  // uses counter c0+i/BB, byte k = ctr[7:0]+k
  function automatic logic [7:0] ks_model(
    input logic [31:0] c0, input int i);
    logic [31:0] c;
    c = c0 + 32'(i / BB);
    return c[7:0] + 8'(i % BB);
  endfunction

  // core stub: 20-cycle latency, BB strobes
  initial begin
    ks_ready_i = 1'b1;
    ks_valid_i = 1'b0;
    ks_byte_i  = 8'h00;
    forever begin
      @(negedge clk);
      if (ks_start_o) begin
        logic [31:0] c;
        c = counter_o;
        starts.push_back(c);
        @(posedge clk); #1;
        ks_ready_i = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        for (int k = 0; k < BB; k++) begin
          if (gap_en && $urandom_range(0, 3) == 0) begin
            ks_valid_i = 1'b0;
            @(posedge clk); #1;
          end
          ks_valid_i = 1'b1;
          ks_byte_i  = c[7:0] + 8'(k);
          @(posedge clk); #1;
        end
        ks_valid_i = 1'b0;
        ks_ready_i = 1'b1;
      end
    end
  end

  // downstream ready
  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready_i = rdy_rand ?
        1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: handshake rules and scoreboard pop
  always @(negedge clk) begin
    if (!rst_i) begin
      chk("hs_sym", 256'(s_valid_i & s_ready_o),
          256'(m_valid_o & m_ready_i));
      if (!m_ready_i)
        chk("ready_gate", 256'(s_ready_o), 0);
      if (ks_valid_i)
        chk("fill_stall", 256'(s_ready_o), 0);
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_extra: got %0h expected none",
                   m_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", 256'(m_data_o), 256'(mon_e[7:0]));
          chk("out_last", 256'(m_last_o), 256'(mon_e[8]));
        end
      end
    end
  end

  task automatic check_reset_outs();
    chk("rst_key", key_o, 0);
    chk("rst_nonce", 256'(nonce_o), 0);
    chk("rst_ctr", 256'(counter_o), 0);
    chk("rst_start", 256'(ks_start_o), 0);
    chk("rst_sready", 256'(s_ready_o), 0);
    chk("rst_mvalid", 256'(m_valid_o), 0);
    chk("rst_mdata", 256'(m_data_o), 0);
    chk("rst_mlast", 256'(m_last_o), 0);
    chk("rst_busy", 256'(busy_o), 0);
    chk("rst_err", 256'(err_o), 0);
  endtask

  task automatic load(input logic [255:0] k,
                      input logic [95:0] n,
                      input logic [31:0] c);
    cfg_key_i     = k;
    cfg_nonce_i   = n;
    cfg_counter_i = c;
    cfg_load_i    = 1'b1;
    msg_c0        = c;
    msg_idx       = 0;
    @(posedge clk); #1;
    cfg_load_i = 1'b0;
    @(negedge clk);
    chk("load_key", key_o, k);
    chk("load_nonce", 256'(nonce_o), 256'(n));
    chk("load_ctr", 256'(counter_o), 256'(c));
    chk("load_busy", 256'(busy_o), 1);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d,
                           input logic last);
    int to;
    bit acc;
    to  = 0;
    acc = 0;
    exp_q.push_back({last, d ^ ks_model(msg_c0, msg_idx)});
    msg_idx++;
    s_data_i = d;
    s_last_i = last;
    while (!acc) begin
      s_valid_i = val_rand ?
        ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = s_valid_i && s_ready_o;
      @(posedge clk); #1;
      to++;
      if (!acc && to > 3000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: got no accept expected accept");
        acc = 1;
      end
    end
    s_valid_i = 1'b0;
  endtask

  task automatic send_msg(input int n, input int mode,
                          input bit last_end);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d = (mode == 0) ? 8'h00 :
          (mode == 1) ? 8'hA5 : 8'($urandom);
      send_byte(d, last_end && (i == n - 1));
    end
  endtask

  task automatic end_msg(input logic [31:0] c);
    @(negedge clk);
    chk("end_busy", 256'(busy_o), 0);
    chk("end_ctr", 256'(counter_o), 256'(c));
    chk("end_queue", 256'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] c;
    int to;
    rst_i         = 1'b1;
    cfg_load_i    = 1'b0;
    cfg_key_i     = '0;
    cfg_nonce_i   = '0;
    cfg_counter_i = '0;
    s_valid_i     = 1'b0;
    s_data_i      = 8'h00;
    s_last_i      = 1'b0;
    msg_c0        = '0;
    msg_idx       = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check_reset_outs();
    @(posedge clk); #1;

    // short message: 05,06,07
    starts.delete();
    load({8{32'h1111_2222}}, {3{32'hABCD_0001}}, 32'd5);
    send_msg(3, 0, 1);
    end_msg(32'd5);
    chk("short_starts", 256'(starts.size()), 1);

    // 130 bytes: blocks 5,6,7
    starts.delete();
    load({8{32'h3333_4444}}, {3{32'h0000_0002}}, 32'd5);
    send_msg(130, 0, 1);
    end_msg(32'd7);
    chk("long_starts", 256'(starts.size()), 3);
    if (starts.size() == 3) begin
      chk("start0", 256'(starts[0]), 5);
      chk("start1", 256'(starts[1]), 6);
      chk("start2", 256'(starts[2]), 7);
    end

    // random handshakes, A5 then random data
    rdy_rand = 1;
    val_rand = 1;
    gap_en   = 1;
    c = $urandom & 32'h7FFF_FFFF;
    load({8{$urandom}}, {3{$urandom}}, c);
    send_msg(150, 1, 1);
    end_msg(c + 32'd2);
    c = $urandom & 32'h7FFF_FFFF;
    load({8{$urandom}}, {3{$urandom}}, c);
    send_msg(100, 2, 1);
    end_msg(c + 32'd1);
    rdy_rand = 0;
    val_rand = 0;
    gap_en   = 0;

    // counter exhaustion
    load({8{32'h5555_6666}}, {3{32'h0000_0003}}, 32'hFFFF_FFFF);
    send_msg(64, 0, 0);
    @(negedge clk);
    chk("err_set", 256'(err_o), 1);
    chk("err_busy", 256'(busy_o), 0);
    chk("err_ctr", 256'(counter_o), 256'(32'hFFFF_FFFF));
    @(posedge clk); #1;
    s_valid_i = 1'b1;
    s_data_i  = 8'h00;
    s_last_i  = 1'b1;
    begin
      int stalls;
      stalls = 0;
      repeat (30) begin
        @(negedge clk);
        if (s_ready_o) stalls++;
      end
      chk("err_stall", 256'(stalls), 0);
    end
    @(posedge clk); #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    chk("err_hold", 256'(err_o), 1);
    load({8{32'h7777_8888}}, {3{32'h0000_0004}}, 32'd100);
    @(negedge clk);
    chk("err_clear", 256'(err_o), 0);
    @(posedge clk); #1;
    send_msg(5, 2, 1);
    end_msg(32'd100);

    // load while streaming is ignored
    load({8{32'h9999_AAAA}}, {3{32'h0000_0005}}, 32'd9);
    send_msg(10, 2, 0);
    cfg_key_i     = {8{32'hDEAD_BEEF}};
    cfg_counter_i = 32'd777;
    cfg_load_i    = 1'b1;
    @(posedge clk); #1;
    cfg_load_i = 1'b0;
    @(negedge clk);
    chk("ign_key", key_o, {8{32'h9999_AAAA}});
    chk("ign_ctr", 256'(counter_o), 9);
    chk("ign_busy", 256'(busy_o), 1);
    @(posedge clk); #1;
    send_msg(60, 2, 1);
    end_msg(32'd10);

    // reset during fill
    load({8{32'hCCCC_DDDD}}, {3{32'h0000_0006}}, 32'd40);
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (!ks_valid_i && to < 500);
    chk("fill_seen", 256'(ks_valid_i), 1);
    repeat (5) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check_reset_outs();
    to = 0;
    while (!ks_ready_i && to < 500) begin
      if (busy_o) begin
        checks++;
        failures++;
        $display("FAIL rst_residual: got busy 1 expected 0");
      end
      @(negedge clk);
      to++;
    end
    @(posedge clk); #1;
    rdy_rand = 1;
    load({8{32'hEEEE_0000}}, {3{32'h0000_0007}}, 32'd50);
    send_msg(70, 2, 1);
    end_msg(32'd51);
    rdy_rand = 0;

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
